// File: rtl/ctrl_word_pkg.sv
// Shared control-word layout, occupancy states and decode helpers for ctrl_word_unpack.
// Optional parity checking is enabled with the CTRL_WORD_PARITY_EN macro.
package ctrl_word_pkg;

   localparam int CW_W       = 16;
   localparam int A_MSB      = 15;
   localparam int A_LSB      = 13;
   localparam int B_MSB      = 12;
   localparam int B_LSB      = 9;
   localparam int CIN_BIT    = 8;
   localparam int C_MSB      = 7;
   localparam int C_LSB      = 4;
   localparam int REC_MSB    = 3;
   localparam int REC_LSB    = 2;
   localparam int PC_EN_BIT  = 1;
   localparam int REG_EN_BIT = 0;

   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_state_e;

   typedef struct packed {
      logic [A_MSB-A_LSB:0]     a;
      logic [B_MSB-B_LSB:0]     b;
      logic                     cin;
      logic [C_MSB-C_LSB:0]     c;
      logic [REC_MSB-REC_LSB:0] rec;
      logic                     pc_en;
      logic                     reg_en;
   } ctrl_fields_t;

   function automatic ctrl_fields_t decode_word(input logic [CW_W-1:0] w);
      ctrl_fields_t f;
      f.a      = w[A_MSB:A_LSB];
      f.b      = w[B_MSB:B_LSB];
      f.cin    = w[CIN_BIT];
      f.c      = w[C_MSB:C_LSB];
      f.rec    = w[REC_MSB:REC_LSB];
      f.pc_en  = w[PC_EN_BIT];
      f.reg_en = w[REG_EN_BIT];
      return f;
   endfunction

   function automatic occ_state_e occ_state(input int occ, input int depth);
      if (occ == 0)     return OCC_EMPTY;
      if (occ >= depth) return OCC_FULL;
      return OCC_PARTIAL;
   endfunction

endpackage

// File: rtl/ctrl_word_fifo.sv
// Circular buffer of control words: memory, wrap-modulo-DEPTH pointers and occupancy.
// Occupancy state is registered so the top-level handshakes depend only on flops.
module ctrl_word_fifo
   import ctrl_word_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_push,
   input  logic            i_pop,
   input  logic [CW_W-1:0] i_din,
   output logic [CW_W-1:0] o_dout,
   output occ_state_e      o_state
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [CW_W-1:0]  r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [OCC_W-1:0] r_occ;
   occ_state_e       r_state;

   logic             w_push;
   logic             w_pop;
   logic [OCC_W-1:0] w_occ_nxt;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Guard here as well so a stray request can never overflow or underflow.
   assign w_push = i_push && (r_state != OCC_FULL);
   assign w_pop  = i_pop  && (r_state != OCC_EMPTY);

   always_comb begin
      w_occ_nxt = r_occ;
      if (w_push && !w_pop)
         w_occ_nxt = r_occ + OCC_W'(1);
      else if (w_pop && !w_push)
         w_occ_nxt = r_occ - OCC_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
         r_state  <= OCC_EMPTY;
      end else begin
         if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         r_occ   <= w_occ_nxt;
         r_state <= occ_state(int'(w_occ_nxt), DEPTH);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_din;
   end

   assign o_dout  = r_mem[r_rd_ptr];
   assign o_state = r_state;

endmodule

// File: rtl/ctrl_word_unpack.sv
// Buffers packed control words and presents the decoded fields of the head word.
// Define CTRL_WORD_PARITY_EN to add in_parity/par_err and drop words with bad parity.
module ctrl_word_unpack
   import ctrl_word_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [CW_W-1:0]  word_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [2:0]       out_a,
   output logic [3:0]       out_b,
   output logic             out_cin,
   output logic [3:0]       out_c,
   output logic [1:0]       out_rec,
   output logic             out_pc_en,
   output logic             out_reg_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] word_count
`ifdef CTRL_WORD_PARITY_EN
   ,
   input  logic             in_parity,
   output logic             par_err
`endif
);

   logic             r_init;
   logic [CNT_W-1:0] r_word_count;
   logic             w_accept;
   logic             w_store;
   logic             w_pop;
   logic [CW_W-1:0]  w_head;
   occ_state_e       w_state;
   ctrl_fields_t     w_fields;

   // in_ready stays low until the first clock edge after reset release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_init <= 1'b0;
      else        r_init <= 1'b1;
   end

   assign in_ready  = r_init && (w_state != OCC_FULL);
   assign out_valid = (w_state != OCC_EMPTY);
   assign w_accept  = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;

`ifdef CTRL_WORD_PARITY_EN
   logic r_par_err;
   logic w_par_bad;

   // A bad-parity word completes the handshake but is dropped.
   assign w_par_bad = ^{word_in, in_parity};
   assign w_store   = w_accept && !w_par_bad;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                      r_par_err <= 1'b0;
      else if (w_accept && w_par_bad)  r_par_err <= 1'b1;
   end

   assign par_err = r_par_err;
`else
   assign w_store = w_accept;
`endif

   ctrl_word_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst_n  (reset),
      .i_push (w_store),
      .i_pop  (w_pop),
      .i_din  (word_in),
      .o_dout (w_head),
      .o_state(w_state)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       r_word_count <= '0;
      else if (w_store) r_word_count <= r_word_count + CNT_W'(1);
   end

   assign word_count = r_word_count;

   // Stale memory contents must not leak out while the buffer is empty.
   assign w_fields   = decode_word(out_valid ? w_head : '0);
   assign out_a      = w_fields.a;
   assign out_b      = w_fields.b;
   assign out_cin    = w_fields.cin;
   assign out_c      = w_fields.c;
   assign out_rec    = w_fields.rec;
   assign out_pc_en  = w_fields.pc_en;
   assign out_reg_en = w_fields.reg_en;

endmodule

// File: tb/tb_ctrl_word_unpack.sv
// Self-checking bench for ctrl_word_unpack: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_ctrl_word_unpack;

   localparam int DEPTH = 2;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [15:0]      word_in = '0;
   logic             in_valid = 1'b0;
   logic             out_ready = 1'b0;
   logic             in_ready;
   logic [2:0]       out_a;
   logic [3:0]       out_b;
   logic             out_cin;
   logic [3:0]       out_c;
   logic [1:0]       out_rec;
   logic             out_pc_en;
   logic             out_reg_en;
   logic             out_valid;
   logic [CNT_W-1:0] word_count;
`ifdef CTRL_WORD_PARITY_EN
   logic             in_parity = 1'b0;
   logic             par_err;
   bit               bad_par = 0;
   bit               mperr = 0;
`endif

   int checks = 0;
   int errors = 0;

   logic [15:0] mq[$];
   int          mcnt = 0;
   bit          mrdy = 0;

   logic [15:0] w_f;
   assign w_f = {out_a, out_b, out_cin, out_c, out_rec, out_pc_en, out_reg_en};

   ctrl_word_unpack #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .word_in   (word_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_cin   (out_cin),
      .out_c     (out_c),
      .out_rec   (out_rec),
      .out_pc_en (out_pc_en),
      .out_reg_en(out_reg_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .word_count(word_count)
`ifdef CTRL_WORD_PARITY_EN
      ,
      .in_parity (in_parity),
      .par_err   (par_err)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [15:0] w;
      logic        ordy;
      logic        vld;
      logic        rdy;
      logic [2:0]  a;
      logic [3:0]  b;
      logic        cin;
      logic [3:0]  c;
      logic [1:0]  rec;
      logic        pc;
      logic        rg;
      logic [7:0]  cnt;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [15:0] w, input logic ordy);
      in_valid  = iv;
      word_in   = w;
      out_ready = ordy;
`ifdef CTRL_WORD_PARITY_EN
      in_parity = (^w) ^ bad_par;
`endif
   endtask

   // Advance DUT and model by one rising edge; returns 1 time unit after the edge.
   task automatic step;
      bit push, pop, good;
      push = in_valid && mrdy && (mq.size() < DEPTH);
      pop  = out_ready && (mq.size() > 0);
      good = 1;
`ifdef CTRL_WORD_PARITY_EN
      good = ((^{word_in, in_parity}) == 1'b0);
      if (push && !good) mperr = 1;
`endif
      @(posedge clk);
      if (pop) void'(mq.pop_front());
      if (push && good) begin
         mq.push_back(word_in);
         mcnt = (mcnt + 1) % (1 << CNT_W);
      end
      mrdy = (reset === 1'b1);
      #1;
   endtask

   task automatic chk_model(input string tag);
      logic [15:0] exp_f;
      exp_f = (mq.size() > 0) ? mq[0] : 16'h0;
      chk({tag, "_vld"}, out_valid, mq.size() > 0);
      chk({tag, "_rdy"}, in_ready, mrdy && (mq.size() < DEPTH));
      chk({tag, "_fld"}, w_f, exp_f);
      chk({tag, "_cnt"}, word_count, mcnt);
`ifdef CTRL_WORD_PARITY_EN
      chk({tag, "_perr"}, par_err, mperr);
`endif
   endtask

   // Asynchronous reset mid-cycle, checked immediately, released off-edge.
   task automatic do_reset;
      #2;
      reset = 1'b0;
      mq.delete();
      mcnt = 0;
      mrdy = 0;
`ifdef CTRL_WORD_PARITY_EN
      mperr = 0;
`endif
      #1;
      chk("rst_vld", out_valid, 0);
      chk("rst_rdy", in_ready, 0);
      chk("rst_fld", w_f, 0);
      chk("rst_cnt", word_count, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      drive(0, 16'h0, 0);
      chk("rel_rdy_pre", in_ready, 0);
      step;
      chk("rel_rdy_post", in_ready, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{1, 16'hA5C3, 0, 1, 1, 5, 2, 1, 4'hC, 0, 1, 1, 1};
      tbl[1]  = '{0, 16'h0000, 1, 0, 1, 0, 0, 0, 0,    0, 0, 0, 1};
      tbl[2]  = '{1, 16'h0001, 0, 1, 1, 0, 0, 0, 0,    0, 0, 1, 2};
      tbl[3]  = '{1, 16'h0002, 0, 1, 0, 0, 0, 0, 0,    0, 0, 1, 3};
      tbl[4]  = '{1, 16'h0003, 0, 1, 0, 0, 0, 0, 0,    0, 0, 1, 3};
      tbl[5]  = '{1, 16'h0003, 1, 1, 1, 0, 0, 0, 0,    0, 1, 0, 3};
      tbl[6]  = '{1, 16'hFFFF, 1, 1, 1, 7, 4'hF, 1, 4'hF, 3, 1, 1, 4};
      tbl[7]  = '{0, 16'h0000, 1, 0, 1, 0, 0, 0, 0,    0, 0, 0, 4};
      tbl[8]  = '{0, 16'h0000, 1, 0, 1, 0, 0, 0, 0,    0, 0, 0, 4};
      tbl[9]  = '{1, 16'h1234, 1, 1, 1, 0, 9, 0, 3,    1, 0, 0, 5};
      tbl[10] = '{0, 16'h0000, 1, 0, 1, 0, 0, 0, 0,    0, 0, 0, 5};

      #1;
      do_reset;

      for (int i = 0; i < 11; i++) begin
         drive(tbl[i].iv, tbl[i].w, tbl[i].ordy);
         step;
         chk($sformatf("v%0d_vld", i), out_valid, tbl[i].vld);
         chk($sformatf("v%0d_rdy", i), in_ready, tbl[i].rdy);
         chk($sformatf("v%0d_a", i), out_a, tbl[i].a);
         chk($sformatf("v%0d_b", i), out_b, tbl[i].b);
         chk($sformatf("v%0d_cin", i), out_cin, tbl[i].cin);
         chk($sformatf("v%0d_c", i), out_c, tbl[i].c);
         chk($sformatf("v%0d_rec", i), out_rec, tbl[i].rec);
         chk($sformatf("v%0d_pc", i), out_pc_en, tbl[i].pc);
         chk($sformatf("v%0d_rg", i), out_reg_en, tbl[i].rg);
         chk($sformatf("v%0d_cnt", i), word_count, tbl[i].cnt);
      end

      // word_count wrap: 256 stored words from a fresh reset
      do_reset;
      for (int i = 0; i < 256; i++) begin
         drive(1, 16'($urandom), 1);
         step;
         if (i == 254) chk("wrap_255", word_count, 255);
      end
      chk("wrap_0", word_count, 0);
      chk_model("wrap");
      drive(1, 16'h5A5A, 0);
      step;
      chk("two_vld", out_valid, 1);
      chk("two_rdy", in_ready, 0);

      // reset with two buffered words: they must be discarded
      do_reset;
      drive(0, 16'h0, 1);
      for (int i = 0; i < 3; i++) begin
         step;
         chk_model($sformatf("post_rst%0d", i));
      end

`ifdef CTRL_WORD_PARITY_EN
      bad_par = 1;
      drive(1, 16'h0001, 0);
      chk("par_in", in_parity, 0);
      step;
      chk("par_err", par_err, 1);
      chk("par_vld", out_valid, 0);
      chk("par_cnt", word_count, 0);
      bad_par = 0;
      drive(0, 16'h0, 0);
      step;
      chk("par_sticky", par_err, 1);
`endif

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 999) == 0) do_reset;
`ifdef CTRL_WORD_PARITY_EN
         bad_par = ($urandom_range(0, 15) == 0);
`endif
         drive($urandom_range(0, 3) != 0, 16'($urandom), 1'($urandom_range(0, 1)));
         step;
         chk_model("rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
